// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan controller: FSM states,
// character codes and active-low segment patterns (bit 6 = a .. bit 0 = g).
package seg7_pkg;

  typedef enum logic [1:0] {
    PARK  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  localparam logic [4:0] CH_BLANK = 5'h10;
  localparam logic [4:0] CH_D     = 5'h11;
  localparam logic [4:0] CH_O     = 5'h12;
  localparam logic [4:0] CH_G     = 5'h13;
  localparam logic [4:0] CH_DASH  = 5'h14;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_O     = 7'b1100010;
  localparam logic [6:0] SEG_G     = 7'b0100001;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  function automatic logic [6:0] hex_seg(input logic [3:0] nib);
    case (nib)
      4'h0:    hex_seg = 7'b0000001;
      4'h1:    hex_seg = 7'b1001111;
      4'h2:    hex_seg = 7'b0010010;
      4'h3:    hex_seg = 7'b0000110;
      4'h4:    hex_seg = 7'b1001100;
      4'h5:    hex_seg = 7'b0100100;
      4'h6:    hex_seg = 7'b0100000;
      4'h7:    hex_seg = 7'b0001111;
      4'h8:    hex_seg = 7'b0000000;
      4'h9:    hex_seg = 7'b0000100;
      4'hA:    hex_seg = 7'b0001000;
      4'hB:    hex_seg = 7'b1100000;
      4'hC:    hex_seg = 7'b0110001;
      4'hD:    hex_seg = 7'b1000010;
      4'hE:    hex_seg = 7'b0110000;
      default: hex_seg = 7'b0111000;
    endcase
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Character write port of the scan controller: one write per cycle, always accepted.
interface seg7_scan_ctrl_if;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [4:0] wr_char;

  modport master (output wr_en, output wr_addr, output wr_char);
  modport slave  (input  wr_en, input  wr_addr, input  wr_char);
endinterface

// File: rtl/seg7_char_decode.sv
// Combinational character-code to active-low segment decode.
module seg7_char_decode
  import seg7_pkg::*;
(
  input  logic [4:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!code[4]) begin
      seg = hex_seg(code[3:0]);
    end else begin
      case (code)
        CH_D:    seg = SEG_D;
        CH_O:    seg = SEG_O;
        CH_G:    seg = SEG_G;
        CH_DASH: seg = SEG_DASH;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: per-digit slot of blanking then display,
// character register file written through the write-port interface.
//
//   state | meaning
//   PARK  | display dark, sequencer idle at digit 0
//   BLANK | ghosting guard at slot start; last cycle latches the digit's character
//   SHOW  | selected digit driven with the latched character
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SLOT_CYC   = 50000,
  parameter int BLANK_CYC  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  seg7_scan_ctrl_if.slave  wr,
  output logic [7:0]       scan,
  output logic [6:0]       seg,
  output logic [2:0]       digit_idx,
  output logic             frame_start
);

  localparam logic [19:0] BLANK_LD   = 20'(BLANK_CYC - 1);
  localparam logic [19:0] SHOW_LD    = 20'(SLOT_CYC - BLANK_CYC - 1);
  localparam logic [2:0]  LAST_DIGIT = 3'(NUM_DIGITS - 1);

  state_t      state;
  logic [19:0] cnt;
  logic [4:0]  disp_reg;
  logic [4:0]  chars [NUM_DIGITS];
  logic [4:0]  cur_char;
  logic [4:0]  dec_in;
  logic [6:0]  dec_out;
  logic [2:0]  next_idx;
  logic        latch;

  // Addresses beyond NUM_DIGITS match no entry, so those writes fall away.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) chars[i] <= CH_BLANK;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (wr.wr_en && wr.wr_addr == 3'(i)) chars[i] <= wr.wr_char;
      end
    end
  end

  always_comb begin
    cur_char = CH_BLANK;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx == 3'(i)) cur_char = chars[i];
    end
  end

  assign latch    = en && (state == BLANK) && (cnt == '0);
  assign dec_in   = latch ? cur_char : disp_reg;
  assign next_idx = (digit_idx == LAST_DIGIT) ? 3'd0 : digit_idx + 3'd1;

  seg7_char_decode u_decode (
    .code (dec_in),
    .seg  (dec_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= PARK;
      cnt         <= '0;
      digit_idx   <= '0;
      scan        <= 8'hFF;
      seg         <= SEG_BLANK;
      frame_start <= 1'b0;
      disp_reg    <= CH_BLANK;
    end else if (!en) begin
      state       <= PARK;
      cnt         <= '0;
      digit_idx   <= '0;
      scan        <= 8'hFF;
      seg         <= SEG_BLANK;
      frame_start <= 1'b0;
    end else begin
      case (state)
        PARK: begin
          state       <= BLANK;
          cnt         <= BLANK_LD;
          digit_idx   <= '0;
          frame_start <= 1'b1;
          scan        <= 8'hFF;
          seg         <= SEG_BLANK;
        end
        BLANK: begin
          frame_start <= 1'b0;
          if (cnt == '0) begin
            state    <= SHOW;
            cnt      <= SHOW_LD;
            disp_reg <= cur_char;
            scan     <= ~(8'd1 << digit_idx);
            seg      <= dec_out;
          end else begin
            cnt <= cnt - 20'd1;
          end
        end
        SHOW: begin
          if (cnt == '0) begin
            state       <= BLANK;
            cnt         <= BLANK_LD;
            digit_idx   <= next_idx;
            frame_start <= (next_idx == 3'd0);
            scan        <= 8'hFF;
            seg         <= SEG_BLANK;
          end else begin
            cnt <= cnt - 20'd1;
            seg <= dec_out;
          end
        end
        default: state <= PARK;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: slot-timing model feeding a scoreboard
// queue, a decode vector table, and hand-written multi-cycle corner sequences.
module tb_seg7_scan_ctrl;

  localparam int SLOT = 8;
  localparam int BLK  = 2;
  localparam int ND   = 4;

  typedef struct packed {
    logic [7:0] scan;
    logic [6:0] seg;
    logic [2:0] idx;
    logic       fs;
  } exp_t;

  typedef struct packed {
    logic [2:0] addr;
    logic [4:0] ch;
    logic [6:0] seg;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] scan;
  logic [6:0] seg;
  logic [2:0] digit_idx;
  logic       frame_start;

  seg7_scan_ctrl_if wr ();

  seg7_scan_ctrl #(.NUM_DIGITS(ND), .SLOT_CYC(SLOT), .BLANK_CYC(BLK)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .wr          (wr),
    .scan        (scan),
    .seg         (seg),
    .digit_idx   (digit_idx),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  int         t = 0;
  bit         running = 1'b0;
  logic [4:0] m_latch;
  logic [4:0] m_chars [ND];
  exp_t       sb_q [$];
  logic [6:0] show_seg [8];
  vec_t       vecs [24];

  function automatic logic [6:0] tb_dec(input logic [4:0] c);
    case (c)
      5'h00: return 7'b0000001;  5'h01: return 7'b1001111;
      5'h02: return 7'b0010010;  5'h03: return 7'b0000110;
      5'h04: return 7'b1001100;  5'h05: return 7'b0100100;
      5'h06: return 7'b0100000;  5'h07: return 7'b0001111;
      5'h08: return 7'b0000000;  5'h09: return 7'b0000100;
      5'h0A: return 7'b0001000;  5'h0B: return 7'b1100000;
      5'h0C: return 7'b0110001;  5'h0D: return 7'b1000010;
      5'h0E: return 7'b0110000;  5'h0F: return 7'b0111000;
      5'h11: return 7'b1000010;  5'h12: return 7'b1100010;
      5'h13: return 7'b0100001;  5'h14: return 7'b1111110;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0d)", name, act, exp, t);
    end
  endtask

  task automatic model_reset();
    running = 1'b0;
    t = 0;
    m_latch = 5'h10;
    for (int i = 0; i < ND; i++) m_chars[i] = 5'h10;
  endtask

  task automatic clear_show();
    for (int i = 0; i < 8; i++) show_seg[i] = 7'h2A;
  endtask

  // One clock: drive inputs, advance the model across the edge, queue the
  // expected outputs, then sample the DUT after the edge and compare.
  task automatic step(input logic en_v, input logic we, input logic [2:0] a, input logic [4:0] c);
    exp_t e, got;
    int ph, d;
    en = en_v;
    wr.wr_en = we;
    wr.wr_addr = a;
    wr.wr_char = c;
    if (!en_v) begin
      running = 1'b0;
      t = 0;
    end else if (!running) begin
      running = 1'b1;
      t = 0;
    end else begin
      if (t % SLOT == BLK - 1) m_latch = m_chars[(t / SLOT) % ND];
      t++;
    end
    if (we && int'(a) < ND) m_chars[int'(a)] = c;
    ph = t % SLOT;
    d  = (t / SLOT) % ND;
    if (!running) begin
      e = '{scan: 8'hFF, seg: 7'h7F, idx: 3'd0, fs: 1'b0};
    end else begin
      e.scan = (ph < BLK) ? 8'hFF : ~(8'd1 << d);
      e.seg  = (ph < BLK) ? 7'h7F : tb_dec(m_latch);
      e.idx  = 3'(d);
      e.fs   = (ph == 0) && (d == 0);
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 8'd0, 8'd1);
    end else begin
      got = sb_q.pop_front();
      chk("sb_scan", scan, got.scan);
      chk("sb_seg", {1'b0, seg}, {1'b0, got.seg});
      chk("sb_idx", {5'b0, digit_idx}, {5'b0, got.idx});
      chk("sb_fs", {7'b0, frame_start}, {7'b0, got.fs});
    end
    if (scan != 8'hFF) show_seg[digit_idx] = seg;
  endtask

  task automatic run_to(input int target);
    for (int k = 0; k < 400 && t < target; k++) step(1'b1, 1'b0, 3'd0, 5'd0);
  endtask

  initial begin
    vecs[0]  = '{3'd0, 5'h00, 7'b0000001};  vecs[1]  = '{3'd1, 5'h01, 7'b1001111};
    vecs[2]  = '{3'd2, 5'h02, 7'b0010010};  vecs[3]  = '{3'd3, 5'h03, 7'b0000110};
    vecs[4]  = '{3'd0, 5'h04, 7'b1001100};  vecs[5]  = '{3'd1, 5'h05, 7'b0100100};
    vecs[6]  = '{3'd2, 5'h06, 7'b0100000};  vecs[7]  = '{3'd3, 5'h07, 7'b0001111};
    vecs[8]  = '{3'd0, 5'h08, 7'b0000000};  vecs[9]  = '{3'd1, 5'h09, 7'b0000100};
    vecs[10] = '{3'd2, 5'h0A, 7'b0001000};  vecs[11] = '{3'd3, 5'h0B, 7'b1100000};
    vecs[12] = '{3'd0, 5'h0C, 7'b0110001};  vecs[13] = '{3'd1, 5'h0D, 7'b1000010};
    vecs[14] = '{3'd2, 5'h0E, 7'b0110000};  vecs[15] = '{3'd3, 5'h0F, 7'b0111000};
    vecs[16] = '{3'd0, 5'h10, 7'h7F};       vecs[17] = '{3'd1, 5'h14, 7'b1111110};
    vecs[18] = '{3'd2, 5'h15, 7'h7F};       vecs[19] = '{3'd3, 5'h1F, 7'h7F};
    vecs[20] = '{3'd0, 5'h11, 7'b1000010};  vecs[21] = '{3'd1, 5'h12, 7'b1100010};
    vecs[22] = '{3'd2, 5'h12, 7'b1100010};  vecs[23] = '{3'd3, 5'h13, 7'b0100001};

    rst = 1'b0;
    en = 1'b0;
    wr.wr_en = 1'b0;
    wr.wr_addr = 3'd0;
    wr.wr_char = 5'd0;
    model_reset();
    clear_show();

    #2 rst = 1'b1;
    #1;
    chk("rst_scan", scan, 8'hFF);
    chk("rst_seg", {1'b0, seg}, 8'h7F);
    chk("rst_idx", {5'b0, digit_idx}, 8'd0);
    chk("rst_fs", {7'b0, frame_start}, 8'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // All blank: slot timing, digit stepping, frame_start every 32 cycles.
    step(1'b1, 1'b0, 3'd0, 5'd0);
    run_to(40);

    // Decode table, four digits per pass, written while parked.
    for (int p = 0; p < 6; p++) begin
      step(1'b0, 1'b0, 3'd0, 5'd0);
      for (int k = 0; k < 4; k++) step(1'b0, 1'b1, vecs[4*p+k].addr, vecs[4*p+k].ch);
      clear_show();
      step(1'b1, 1'b0, 3'd0, 5'd0);
      run_to(31);
      for (int k = 0; k < 4; k++)
        chk("table_seg", {1'b0, show_seg[vecs[4*p+k].addr]}, {1'b0, vecs[4*p+k].seg});
    end

    // Write to digit 1 while it is showing: old pattern holds to slot end.
    run_to(43);
    step(1'b1, 1'b1, 3'd1, 5'h05);
    run_to(47);
    chk("wr_show_hold", {1'b0, show_seg[1]}, {1'b0, 7'b1100010});
    run_to(79);
    chk("wr_show_next", {1'b0, show_seg[1]}, {1'b0, 7'b0100100});

    // Write coinciding with digit 2 latch cycle: old value this frame.
    run_to(113);
    step(1'b1, 1'b1, 3'd2, 5'h14);
    run_to(119);
    chk("latch_old", {1'b0, show_seg[2]}, {1'b0, 7'b1100010});
    run_to(151);
    chk("latch_new", {1'b0, show_seg[2]}, {1'b0, 7'b1111110});

    // Out-of-range address is ignored for two frames.
    step(1'b1, 1'b1, 3'd5, 5'h13);
    for (int f = 1; f <= 2; f++) begin
      clear_show();
      run_to(152 + 32 * f);
      chk("oor_d0", {1'b0, show_seg[0]}, {1'b0, 7'b1000010});
      chk("oor_d1", {1'b0, show_seg[1]}, {1'b0, 7'b0100100});
      chk("oor_d2", {1'b0, show_seg[2]}, {1'b0, 7'b1111110});
      chk("oor_d3", {1'b0, show_seg[3]}, {1'b0, 7'b0100001});
    end

    // en dropped during digit 2 SHOW, then re-asserted.
    run_to(244);
    chk("pre_drop_idx", {5'b0, digit_idx}, 8'd2);
    step(1'b0, 1'b0, 3'd0, 5'd0);
    chk("drop_scan", scan, 8'hFF);
    chk("drop_idx", {5'b0, digit_idx}, 8'd0);
    step(1'b0, 1'b0, 3'd0, 5'd0);
    step(1'b1, 1'b0, 3'd0, 5'd0);
    chk("reen_fs", {7'b0, frame_start}, 8'd1);
    chk("reen_scan", scan, 8'hFF);

    // Asynchronous reset between edges mid-SHOW.
    run_to(12);
    #2 rst = 1'b1;
    #1;
    chk("arst_scan", scan, 8'hFF);
    chk("arst_seg", {1'b0, seg}, 8'h7F);
    chk("arst_idx", {5'b0, digit_idx}, 8'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    clear_show();
    step(1'b1, 1'b0, 3'd0, 5'd0);
    chk("arst_restart_fs", {7'b0, frame_start}, 8'd1);
    run_to(31);
    for (int i = 0; i < ND; i++) chk("arst_blank", {1'b0, show_seg[i]}, 8'h7F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
